// File: rtl/ex_mem_reg_pkg.sv
// Shared CPU definitions used by the EX/MEM pipeline register:
// exception cause codes, the trap FSM encoding, writeback select
// encodings shared with ID and WB, and the registered control bundle.
package ex_mem_reg_pkg;

    // Cause code reported for an arithmetic-overflow trap.
    localparam logic [4:0] CAUSE_OVF = 5'd12;

    // Exception FSM: RUN loads normally, TRAP squashes until acknowledged.
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    // Writeback source select, common to ID, MEM and WB.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    // Control bundle carried from EX into MEM.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        wb_sel_t    mem_to_reg;
        logic [4:0] write_reg;
    } ctrl_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-to-MEM bus: EX-stage inputs, MEM-stage outputs and the overflow
// exception request. The master side drives EX and pipeline control,
// the slave side is the pipeline register itself.
interface ex_mem_reg_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_alu_result;
    logic             ex_zero;
    logic             ex_negative;
    logic             ex_overflow;
    logic             ex_ovf_trap_en;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [1:0]       ex_mem_to_reg;
    logic [4:0]       ex_write_reg;
    logic [31:0]      ex_store_data;
    logic             exc_ack;

    logic             mem_valid;
    logic [31:0]      mem_pc;
    logic [31:0]      mem_alu_result;
    logic             mem_zero;
    logic             mem_negative;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic [1:0]       mem_mem_to_reg;
    logic [4:0]       mem_write_reg;
    logic [31:0]      mem_store_data;
    logic             exc_req;
    logic [31:0]      exc_epc;
    logic [4:0]       exc_cause;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output stall, flush, ex_valid, ex_pc, ex_alu_result, ex_zero,
               ex_negative, ex_overflow, ex_ovf_trap_en, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_write_reg,
               ex_store_data, exc_ack,
        input  mem_valid, mem_pc, mem_alu_result, mem_zero, mem_negative,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               mem_write_reg, mem_store_data, exc_req, exc_epc, exc_cause,
               ovf_count
    );

    modport slave (
        input  stall, flush, ex_valid, ex_pc, ex_alu_result, ex_zero,
               ex_negative, ex_overflow, ex_ovf_trap_en, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_write_reg,
               ex_store_data, exc_ack,
        output mem_valid, mem_pc, mem_alu_result, mem_zero, mem_negative,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               mem_write_reg, mem_store_data, exc_req, exc_epc, exc_cause,
               ovf_count
    );

endinterface

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Reusable for any event counter in the pipeline.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Synchronous clear wins; increments stop once the count is all-ones.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. Captures the ALU result, flags and EX
// control bundle for the MEM stage, and converts a trapping signed
// overflow into a precise exception: the faulting instruction and all
// younger ones are replaced by bubbles until the handler acknowledges.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter logic [4:0] OVF_CAUSE = CAUSE_OVF,
    parameter int         CNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    ex_mem_reg_if.slave    bus
);

    state_t           state_q;
    logic             exc_req_q;
    logic [31:0]      epc_q;
    logic [4:0]       cause_q;

    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic [31:0]      result_p1;
    logic             zero_p1;
    logic             neg_p1;
    ctrl_t            ctrl_p1;
    logic [31:0]      store_p1;

    ctrl_t            ctrl_in;
    logic             take_trap;
    logic             squash;
    logic [CNT_W-1:0] ovf_cnt;

    assign ctrl_in = '{
        reg_write:  bus.ex_reg_write,
        mem_read:   bus.ex_mem_read,
        mem_write:  bus.ex_mem_write,
        mem_to_reg: wb_sel_t'(bus.ex_mem_to_reg),
        write_reg:  bus.ex_write_reg
    };

    // A trap is only taken on a real load edge: RUN, not flushed, not stalled.
    assign take_trap = (state_q == RUN) && !bus.flush && !bus.stall &&
                       bus.ex_valid && bus.ex_ovf_trap_en && bus.ex_overflow;

    // Bubble sources in priority order below reset: flush, TRAP, the fault itself.
    assign squash = bus.flush || (state_q == TRAP) || take_trap;

    // ---- EX -> MEM stage boundary ----
    // Stage register: bubble on squash, hold on stall, otherwise load EX.
    always_ff @(posedge clk) begin
        if (reset || squash) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            neg_p1    <= 1'b0;
            ctrl_p1   <= '0;
            store_p1  <= '0;
        end else if (!bus.stall) begin
            vld_p1    <= bus.ex_valid;
            pc_p1     <= bus.ex_pc;
            result_p1 <= bus.ex_alu_result;
            zero_p1   <= bus.ex_zero;
            neg_p1    <= bus.ex_negative;
            ctrl_p1   <= ctrl_in;
            store_p1  <= bus.ex_store_data;
        end
    end

    // Exception FSM with registered request; EPC/cause persist after returning to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            exc_req_q <= 1'b0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take_trap) begin
                        state_q   <= TRAP;
                        exc_req_q <= 1'b1;
                        epc_q     <= bus.ex_pc;
                        cause_q   <= OVF_CAUSE;
                    end
                end
                TRAP: begin
                    if (bus.exc_ack) begin
                        state_q   <= RUN;
                        exc_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    exc_req_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (take_trap),
        .count (ovf_cnt)
    );

    assign bus.mem_valid      = vld_p1;
    assign bus.mem_pc         = pc_p1;
    assign bus.mem_alu_result = result_p1;
    assign bus.mem_zero       = zero_p1;
    assign bus.mem_negative   = neg_p1;
    assign bus.mem_reg_write  = ctrl_p1.reg_write;
    assign bus.mem_mem_read   = ctrl_p1.mem_read;
    assign bus.mem_mem_write  = ctrl_p1.mem_write;
    assign bus.mem_mem_to_reg = ctrl_p1.mem_to_reg;
    assign bus.mem_write_reg  = ctrl_p1.write_reg;
    assign bus.mem_store_data = store_p1;
    assign bus.exc_req        = exc_req_q;
    assign bus.exc_epc        = epc_q;
    assign bus.exc_cause      = cause_q;
    assign bus.ovf_count      = ovf_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios followed by random
// traffic, all checked against a behavioural model of the pipeline
// register, the overflow exception and the saturating trap counter.
module tb_ex_mem_reg;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ex_mem_reg_if #(.CNT_W(CW)) bus ();

    ex_mem_reg #(
        .OVF_CAUSE (5'd12),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: expected outputs after the most recent edge.
    bit          m_trapped;
    logic        m_valid, m_zero, m_neg, m_rw, m_mr, m_mw;
    logic [1:0]  m_m2r;
    logic [4:0]  m_wr, m_cause;
    logic [31:0] m_pc, m_res, m_sd, m_epc;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 0; m_pc = 0; m_res = 0; m_zero = 0; m_neg = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_wr = 0; m_sd = 0;
    endtask

    // Apply the update rules for one rising edge using the current inputs.
    task automatic model_edge();
        bit fault;
        if (reset) begin
            model_bubble();
            m_trapped = 0; m_epc = 0; m_cause = 0; m_cnt = 0;
        end else begin
            fault = !m_trapped && !bus.flush && !bus.stall &&
                    bus.ex_valid && bus.ex_ovf_trap_en && bus.ex_overflow;
            if (bus.flush || m_trapped || fault) begin
                model_bubble();
            end else if (!bus.stall) begin
                m_valid = bus.ex_valid;       m_pc  = bus.ex_pc;
                m_res   = bus.ex_alu_result;  m_zero = bus.ex_zero;
                m_neg   = bus.ex_negative;    m_rw  = bus.ex_reg_write;
                m_mr    = bus.ex_mem_read;    m_mw  = bus.ex_mem_write;
                m_m2r   = bus.ex_mem_to_reg;  m_wr  = bus.ex_write_reg;
                m_sd    = bus.ex_store_data;
            end
            if (fault) begin
                m_trapped = 1;
                m_epc     = bus.ex_pc;
                m_cause   = 5'd12;
                if (m_cnt < CMAX) m_cnt++;
            end else if (m_trapped && bus.exc_ack) begin
                m_trapped = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_valid",      32'(bus.mem_valid),      32'(m_valid));
        chk("mem_pc",         bus.mem_pc,              m_pc);
        chk("mem_alu_result", bus.mem_alu_result,      m_res);
        chk("mem_zero",       32'(bus.mem_zero),       32'(m_zero));
        chk("mem_negative",   32'(bus.mem_negative),   32'(m_neg));
        chk("mem_reg_write",  32'(bus.mem_reg_write),  32'(m_rw));
        chk("mem_mem_read",   32'(bus.mem_mem_read),   32'(m_mr));
        chk("mem_mem_write",  32'(bus.mem_mem_write),  32'(m_mw));
        chk("mem_mem_to_reg", 32'(bus.mem_mem_to_reg), 32'(m_m2r));
        chk("mem_write_reg",  32'(bus.mem_write_reg),  32'(m_wr));
        chk("mem_store_data", bus.mem_store_data,      m_sd);
        chk("exc_req",        32'(bus.exc_req),        32'(m_trapped));
        chk("exc_epc",        bus.exc_epc,             m_epc);
        chk("exc_cause",      32'(bus.exc_cause),      32'(m_cause));
        chk("ovf_count",      32'(bus.ovf_count),      32'(m_cnt));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_in();
        bus.stall = 0; bus.flush = 0; bus.ex_valid = 0; bus.ex_pc = 0;
        bus.ex_alu_result = 0; bus.ex_zero = 0; bus.ex_negative = 0;
        bus.ex_overflow = 0; bus.ex_ovf_trap_en = 0; bus.ex_reg_write = 0;
        bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.ex_mem_to_reg = 0;
        bus.ex_write_reg = 0; bus.ex_store_data = 0; bus.exc_ack = 0;
    endtask

    task automatic rand_data();
        bus.ex_valid       = ($urandom_range(0, 7) != 0);
        bus.ex_pc          = $urandom & 32'hFFFF_FFFC;
        bus.ex_alu_result  = $urandom;
        bus.ex_zero        = 1'($urandom);
        bus.ex_negative    = 1'($urandom);
        bus.ex_reg_write   = 1'($urandom);
        bus.ex_mem_read    = 1'($urandom);
        bus.ex_mem_write   = 1'($urandom);
        bus.ex_mem_to_reg  = 2'($urandom);
        bus.ex_write_reg   = 5'($urandom);
        bus.ex_store_data  = $urandom;
    endtask

    task automatic trap_in(input logic [31:0] pc);
        clr_in();
        bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_alu_result = 32'h8000_0000;
        bus.ex_negative = 1; bus.ex_overflow = 1; bus.ex_ovf_trap_en = 1;
        bus.ex_reg_write = 1; bus.ex_write_reg = 5'd9;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Reset for two cycles with busy inputs.
        rand_data();
        bus.stall = 0; bus.flush = 0; bus.exc_ack = 1;
        bus.ex_overflow = 1; bus.ex_ovf_trap_en = 1;
        reset = 1;
        step();
        step();
        chk("rst_exc_req", 32'(bus.exc_req), 32'd0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        reset = 0;

        // Simple load.
        clr_in();
        bus.ex_valid = 1; bus.ex_alu_result = 32'd5; bus.ex_reg_write = 1; bus.ex_write_reg = 5'd8;
        step();
        chk("load_result", bus.mem_alu_result, 32'd5);
        chk("load_wr", 32'(bus.mem_write_reg), 32'd8);

        // Stall three cycles with changing inputs, then flush+stall.
        for (int i = 0; i < 3; i++) begin
            rand_data();
            bus.stall = 1;
            step();
            chk("stall_hold", bus.mem_alu_result, 32'd5);
        end
        bus.flush = 1;
        step();
        chk("flush_stall_valid", 32'(bus.mem_valid), 32'd0);
        bus.flush = 0; bus.stall = 0;

        // Trapping add, two squashed younger instructions, ack on third.
        trap_in(32'h0040_0010);
        step();
        chk("trap_req", 32'(bus.exc_req), 32'd1);
        chk("trap_epc", bus.exc_epc, 32'h0040_0010);
        chk("trap_cause", 32'(bus.exc_cause), 32'd12);
        chk("trap_rw", 32'(bus.mem_reg_write), 32'd0);
        for (int i = 0; i < 2; i++) begin
            rand_data();
            bus.ex_valid = 1; bus.ex_overflow = 0;
            step();
            chk("young_squash", 32'(bus.mem_valid), 32'd0);
        end
        rand_data();
        bus.ex_valid = 1; bus.exc_ack = 1;
        step();
        chk("ack_req", 32'(bus.exc_req), 32'd0);
        chk("ack_squash", 32'(bus.mem_valid), 32'd0);
        clr_in();
        bus.ex_valid = 1; bus.ex_alu_result = 32'h1234_5678;
        step();
        chk("resume_valid", 32'(bus.mem_valid), 32'd1);
        chk("epc_kept", bus.exc_epc, 32'h0040_0010);

        // Same overflow without trap enable loads normally.
        trap_in(32'h0040_0020);
        bus.ex_ovf_trap_en = 0;
        step();
        chk("addu_result", bus.mem_alu_result, 32'h8000_0000);
        chk("addu_req", 32'(bus.exc_req), 32'd0);

        // Reset in the middle of TRAP.
        trap_in(32'h0040_0030);
        step();
        clr_in();
        reset = 1;
        step();
        chk("rst_mid_trap", 32'(bus.exc_req), 32'd0);
        reset = 0;

        // Counter saturation across five acked traps.
        for (int k = 0; k < 5; k++) begin
            trap_in(32'h0040_1000 + 32'(k * 4));
            step();
            chk("sat_count", 32'(bus.ovf_count), 32'(sat_exp[k]));
            clr_in();
            bus.exc_ack = 1;
            step();
        end

        // Trap held off by stall until stall drops.
        trap_in(32'h0040_2000);
        bus.stall = 1;
        step();
        chk("stall_no_trap", 32'(bus.exc_req), 32'd0);
        bus.stall = 0;
        step();
        chk("trap_after_stall", 32'(bus.exc_req), 32'd1);
        clr_in();
        bus.exc_ack = 1;
        step();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rand_data();
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.ex_overflow    = ($urandom_range(0, 2) == 0);
            bus.ex_ovf_trap_en = 1'($urandom);
            bus.exc_ack        = ($urandom_range(0, 3) == 0);
            reset              = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
